// File: rtl/bus_m_fetch_queue.sv
// Instruction-fetch prefetch queue: issues word reads from a fetch PC toward the
// AHB master adaptor and buffers returned words in a small FIFO for decode.
module bus_m_fetch_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h9000_0000,
  parameter logic [3:0]  FETCH_PROT   = 4'b0010
) (
  input  logic        CLK,
  input  logic        RES_SYS,
  input  logic        FETCH_FLUSH,
  input  logic [31:0] FETCH_TARGET,
  output logic        FETCH_VALID,
  input  logic        FETCH_READY,
  output logic [31:0] FETCH_DATA,
  output logic [31:0] FETCH_ADDR,
  output logic        FETCH_ERR,
  output logic        BUS_M_REQ,
  input  logic        BUS_M_ACK,
  output logic        BUS_M_SEQ,
  output logic        BUS_M_CONT,
  output logic [2:0]  BUS_M_BURST,
  output logic        BUS_M_LOCK,
  output logic [3:0]  BUS_M_PROT,
  output logic        BUS_M_WRITE,
  output logic [1:0]  BUS_M_SIZE,
  output logic [31:0] BUS_M_ADDR,
  output logic [31:0] BUS_M_WDATA,
  input  logic        BUS_M_LAST,
  input  logic [31:0] BUS_M_RDATA,
  input  logic [3:0]  BUS_M_DONE
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic {RUN, ERR_HOLD} state_t;

  state_t        state, state_n;
  logic [31:0]   fetch_pc, resp_pc;
  logic [CW-1:0] fifo_count, outstanding, outstanding_n, discard;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW:0]   credit_sum;
  logic          acc, rsp, take_discard, push, pop;

  logic [31:0]      mem_data [DEPTH];
  logic [31:0]      mem_addr [DEPTH];
  logic [DEPTH-1:0] mem_err;

  logic unused_ok;
  assign unused_ok = &{1'b0, BUS_M_LAST, BUS_M_DONE[2], FETCH_TARGET[1:0]};

  always_comb begin
    credit_sum    = {1'b0, fifo_count} + {1'b0, outstanding};
    BUS_M_REQ     = (state == RUN) && !FETCH_FLUSH && (credit_sum < (CW+1)'(DEPTH));
    acc           = BUS_M_REQ && BUS_M_ACK;
    rsp           = BUS_M_DONE[0] && !BUS_M_DONE[1];
    take_discard  = rsp && (discard != '0);
    // A response arriving during a flush still retires its outstanding slot.
    push          = rsp && !FETCH_FLUSH && !take_discard;
    pop           = FETCH_VALID && FETCH_READY && !FETCH_FLUSH;
    outstanding_n = outstanding + CW'(acc) - CW'(rsp);
    state_n       = state;
    if (FETCH_FLUSH)
      state_n = RUN;
    else if (push && BUS_M_DONE[3])
      state_n = ERR_HOLD;
  end

  always_ff @(posedge CLK) begin
    if (RES_SYS)
      state <= RUN;
    else
      state <= state_n;
  end

  always_ff @(posedge CLK) begin
    if (RES_SYS) begin
      fetch_pc    <= RESET_VECTOR;
      resp_pc     <= RESET_VECTOR;
      fifo_count  <= '0;
      outstanding <= '0;
      discard     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding_n;
      if (FETCH_FLUSH) begin
        fetch_pc   <= {FETCH_TARGET[31:2], 2'b00};
        resp_pc    <= {FETCH_TARGET[31:2], 2'b00};
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        discard    <= outstanding_n;
      end else begin
        if (acc)
          fetch_pc <= fetch_pc + 32'd4;
        if (take_discard)
          discard <= discard - CW'(1);
        if (push) begin
          wr_ptr  <= wr_ptr + AW'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_data[wr_ptr] <= BUS_M_RDATA;
      mem_addr[wr_ptr] <= resp_pc;
      mem_err[wr_ptr]  <= BUS_M_DONE[3];
    end
  end

  always_comb begin
    FETCH_VALID = (fifo_count != '0);
    FETCH_DATA  = FETCH_VALID ? mem_data[rd_ptr] : '0;
    FETCH_ADDR  = FETCH_VALID ? mem_addr[rd_ptr] : '0;
    FETCH_ERR   = FETCH_VALID ? mem_err[rd_ptr]  : 1'b0;
  end

  assign BUS_M_SEQ   = 1'b0;
  assign BUS_M_CONT  = 1'b0;
  assign BUS_M_BURST = 3'b000;
  assign BUS_M_LOCK  = 1'b0;
  assign BUS_M_PROT  = FETCH_PROT;
  assign BUS_M_WRITE = 1'b0;
  assign BUS_M_SIZE  = 2'b10;
  assign BUS_M_ADDR  = {fetch_pc[31:2], 2'b00};
  assign BUS_M_WDATA = '0;

  // The credit limit must make a push into a full FIFO impossible.
  assert property (@(posedge CLK) disable iff (RES_SYS)
                   !(push && (fifo_count == CW'(DEPTH))));

endmodule

// File: tb/tb_bus_m_fetch_queue.sv
// Bench for bus_m_fetch_queue: in-order slave with programmable wait states and
// a queue-based reference model of the fetch queue.
module tb_bus_m_fetch_queue;

  logic        CLK = 1'b0;
  logic        RES_SYS, flush, ready;
  logic [31:0] target;
  logic        fetch_valid, fetch_err;
  logic [31:0] fetch_data, fetch_addr;
  logic        bus_req, bus_ack, ack_en, slave_ok;
  logic        bus_seq, bus_cont, bus_lock, bus_write;
  logic [2:0]  bus_burst;
  logic [3:0]  bus_prot, done;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, rdata;

  assign bus_ack = bus_req & ack_en & slave_ok;

  always #5 CLK = ~CLK;

  bus_m_fetch_queue #(.DEPTH(4), .RESET_VECTOR(32'h9000_0000), .FETCH_PROT(4'b0010)) dut (
    .CLK(CLK), .RES_SYS(RES_SYS), .FETCH_FLUSH(flush), .FETCH_TARGET(target),
    .FETCH_VALID(fetch_valid), .FETCH_READY(ready), .FETCH_DATA(fetch_data),
    .FETCH_ADDR(fetch_addr), .FETCH_ERR(fetch_err), .BUS_M_REQ(bus_req),
    .BUS_M_ACK(bus_ack), .BUS_M_SEQ(bus_seq), .BUS_M_CONT(bus_cont),
    .BUS_M_BURST(bus_burst), .BUS_M_LOCK(bus_lock), .BUS_M_PROT(bus_prot),
    .BUS_M_WRITE(bus_write), .BUS_M_SIZE(bus_size), .BUS_M_ADDR(bus_addr),
    .BUS_M_WDATA(bus_wdata), .BUS_M_LAST(1'b0), .BUS_M_RDATA(rdata), .BUS_M_DONE(done)
  );

  typedef struct { logic [31:0] a; int unsigned w; } sl_t;
  typedef struct { logic e; logic [31:0] a; logic [31:0] d; } ent_t;
  typedef struct {
    logic        ready;
    logic        ack_en;
    logic        exp_req;
    logic [31:0] exp_baddr;
    logic        exp_valid;
    logic [31:0] exp_faddr;
    logic [31:0] exp_fdata;
  } vec_t;

  sl_t         slq[$];
  ent_t        mq[$];
  logic [31:0] ack_log[$], pop_log[$];
  logic        pop_err_log[$];
  int unsigned wait_n, slave_max, ack_cnt;
  logic [31:0] err_addr, m_fpc, m_rpc;
  int          m_out, m_disc;
  bit          m_hold;
  int          errors = 0, checks = 0;
  logic        s_req, s_valid, s_err;
  logic [31:0] s_baddr, s_faddr, s_fdata;
  vec_t        tbl[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive slave response, compare against model, advance model and slave.
  task automatic step();
    bit          rsp_now, m_req, m_acc, a_ack;
    logic [31:0] a_addr;
    ent_t        h;
    logic [98:0] act, exp;
    slave_ok = (slq.size() < int'(slave_max));
    rsp_now  = (slq.size() > 0) && (slq[0].w == 0);
    if (rsp_now) begin
      done  = (slq[0].a == err_addr) ? 4'b1001 : 4'b0001;
      rdata = slq[0].a ^ 32'hFFFF_FFFF;
    end else begin
      done  = 4'b0000;
      rdata = $urandom;
    end
    #1;
    m_req = !m_hold && !flush && (mq.size() + m_out < 4);
    m_acc = m_req && ack_en && slave_ok;
    h = '{default: '0};
    if (mq.size() > 0) h = mq[0];
    exp = {m_req, m_fpc, mq.size() != 0, h.a, h.d, h.e};
    act = {bus_req, bus_addr, fetch_valid, fetch_addr, fetch_data, fetch_err};
    {s_req, s_baddr, s_valid, s_faddr, s_fdata, s_err} = act;
    chk("model", {29'd0, act}, {29'd0, exp});
    a_ack  = bus_ack;
    a_addr = bus_addr;
    @(posedge CLK);
    if (rsp_now) void'(slq.pop_front());
    else if (slq.size() > 0 && slq[0].w > 0) slq[0].w--;
    if (a_ack) begin
      slq.push_back('{a_addr, wait_n});
      ack_log.push_back(a_addr);
      ack_cnt++;
    end
    if (flush) begin
      mq.delete();
      m_fpc  = {target[31:2], 2'b00};
      m_rpc  = m_fpc;
      m_out  = m_out - int'(rsp_now);
      m_disc = m_out;
      m_hold = 0;
    end else begin
      if (mq.size() > 0 && ready) begin
        pop_log.push_back(mq[0].a);
        pop_err_log.push_back(mq[0].e);
        void'(mq.pop_front());
      end
      if (rsp_now) begin
        if (m_disc > 0) m_disc--;
        else begin
          mq.push_back('{done[3], m_rpc, rdata});
          m_rpc = m_rpc + 32'd4;
          if (done[3]) m_hold = 1;
        end
      end
      if (m_acc) m_fpc = m_fpc + 32'd4;
      m_out = m_out + int'(m_acc) - int'(rsp_now);
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RES_SYS = 1; ack_en = 0; flush = 0; ready = 0; done = '0; target = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RES_SYS = 0;
    slq.delete(); mq.delete(); ack_log.delete(); pop_log.delete(); pop_err_log.delete();
    m_fpc = 32'h9000_0000; m_rpc = 32'h9000_0000;
    m_out = 0; m_disc = 0; m_hold = 0; ack_cnt = 0;
  endtask

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (q.size() > i) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit found;
    slave_max = 2; wait_n = 0; err_addr = 32'h1; rdata = '0;
    tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h9000_0000, 1'b0, 32'h0,         32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h9000_0004, 1'b0, 32'h0,         32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h9000_0008, 1'b1, 32'h9000_0000, 32'h6FFF_FFFF};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h9000_000C, 1'b1, 32'h9000_0004, 32'h6FFF_FFFB};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h9000_0010, 1'b1, 32'h9000_0008, 32'h6FFF_FFF7};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h9000_0014, 1'b1, 32'h9000_000C, 32'h6FFF_FFF3};

    // Zero-wait streaming from reset.
    do_reset();
    chk("const", {bus_seq, bus_cont, bus_burst, bus_lock, bus_prot, bus_write, bus_size, bus_wdata},
                 {1'b0, 1'b0, 3'b000, 1'b0, 4'b0010, 1'b0, 2'b10, 32'h0});
    for (int i = 0; i < 6; i++) begin
      ready = tbl[i].ready; ack_en = tbl[i].ack_en;
      step();
      chk($sformatf("tbl%0d", i), {s_req, s_baddr, s_valid, s_faddr, s_fdata},
          {tbl[i].exp_req, tbl[i].exp_baddr, tbl[i].exp_valid, tbl[i].exp_faddr, tbl[i].exp_fdata});
    end

    // Consumer stalled: credit stops at DEPTH, then resumes.
    do_reset();
    ack_en = 1; ready = 0;
    repeat (10) step();
    chk("stall_acks", ack_cnt, 4);
    chk("stall_req", s_req, 1'b0);
    ready = 1;
    repeat (10) step();
    for (int i = 0; i < 4; i++)
      chk($sformatf("stall_pop%0d", i), at(pop_log, i), 32'h9000_0000 + 32'(4 * i));
    chk("resume_addr", at(ack_log, 4), 32'h9000_0010);

    // Flush with two reads outstanding.
    do_reset();
    wait_n = 3; ack_en = 1; ready = 1; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out == 2) found = 1;
      else step();
    end
    chk("flush2_reach", found, 1'b1);
    flush = 1; target = 32'h0000_1236;
    step();
    flush = 0; ack_log.delete(); pop_log.delete();
    step();
    chk("flush2_empty", s_valid, 1'b0);
    repeat (25) step();
    chk("flush2_ack", at(ack_log, 0), 32'h0000_1234);
    chk("flush2_pop", at(pop_log, 0), 32'h0000_1234);

    // Flush coinciding with a response and a pop, one read still outstanding.
    do_reset();
    wait_n = 3; ack_en = 1; ready = 0; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (slq.size() > 0 && slq[0].w == 0 && mq.size() > 0 && m_out == 2) begin
        ready = 1; flush = 1; target = 32'h0000_2000;
        step();
        flush = 0; found = 1;
      end else step();
    end
    chk("flush_rsp_reach", found, 1'b1);
    ack_log.delete(); pop_log.delete();
    step();
    chk("flush_rsp_empty", s_valid, 1'b0);
    repeat (25) step();
    chk("flush_rsp_pop", at(pop_log, 0), 32'h0000_2000);

    // Bus error on 0x90000008.
    do_reset();
    wait_n = 0; ack_en = 1; ready = 1; err_addr = 32'h9000_0008;
    repeat (12) step();
    chk("err_acks", ack_cnt, 4);
    chk("err_pop_addr", at(pop_log, 2), 32'h9000_0008);
    chk("err_flag", (pop_err_log.size() > 2) ? pop_err_log[2] : 1'bx, 1'b1);
    chk("err_inflight", at(pop_log, 3), 32'h9000_000C);
    chk("err_noreq", s_req, 1'b0);
    flush = 1; target = 32'h0000_0100;
    step();
    flush = 0; ack_log.delete();
    repeat (4) step();
    chk("err_resume", at(ack_log, 0), 32'h0000_0100);
    err_addr = 32'h1;

    // Three wait states on every access.
    do_reset();
    wait_n = 3; ack_en = 1; ready = 1;
    repeat (60) step();
    chk("wait3_order", at(pop_log, 5), 32'h9000_0014);

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) err_addr = m_fpc + 32'(4 * $urandom_range(1, 6));
      flush  = ($urandom_range(0, 39) == 0);
      target = $urandom;
      ready  = ($urandom_range(0, 3) != 0);
      ack_en = ($urandom_range(0, 2) != 0);
      wait_n = $urandom_range(0, 3);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_m_fetch_queue.md
Name: bus_m_fetch_queue

Overview:
Instruction-fetch prefetch queue that sits directly upstream of the AHB bus master adaptor. It generates BUS_M_* word-read commands from an internal fetch PC and consumes the registered BUS_M_DONE/BUS_M_RDATA responses. Fetched words are buffered in a small FIFO that feeds the CPU decode stage. Flush/redirect support discards in-flight responses.

Parameters:
DEPTH, 4, FIFO entries (power of 2, 2..8); also the credit limit for fifo_count + outstanding
RESET_VECTOR, 32'h90000000, fetch PC after reset (word aligned)
FETCH_PROT, 4'b0010, BUS_M_PROT value (privileged, opcode fetch)

Ports:
CLK  in  1  system clock
RES_SYS  in  1  synchronous active-high reset
FETCH_FLUSH  in  1  redirect: drop queue and in-flight data, restart at FETCH_TARGET
FETCH_TARGET  in  32  redirect address; bits [1:0] ignored
FETCH_VALID  out  1  head entry available
FETCH_READY  in  1  consumer pops head when FETCH_VALID & FETCH_READY & ~FETCH_FLUSH
FETCH_DATA  out  32  head instruction word
FETCH_ADDR  out  32  head word address
FETCH_ERR  out  1  head entry returned bus error
BUS_M_REQ  out  1  command request
BUS_M_ACK  in  1  command accepted (combinational from adaptor)
BUS_M_SEQ  out  1  constant 0
BUS_M_CONT  out  1  constant 0
BUS_M_BURST  out  3  constant 3'b000
BUS_M_LOCK  out  1  constant 0
BUS_M_PROT  out  4  FETCH_PROT
BUS_M_WRITE  out  1  constant 0
BUS_M_SIZE  out  2  constant 2'b10 (word)
BUS_M_ADDR  out  32  {fetch_pc[31:2], 2'b00}
BUS_M_WDATA  out  32  constant 0
BUS_M_LAST  in  1  unused, kept for port compatibility
BUS_M_RDATA  in  32  read data, valid when BUS_M_DONE[1:0]==2'b01
BUS_M_DONE  in  4  {BUSERR, EXCEPTION, WRITE, DONE}

Behaviour:
- State: RUN, ERR_HOLD. Reset -> RUN, fetch_pc = resp_pc = RESET_VECTOR, fifo empty, outstanding = 0, discard = 0. After reset FETCH_VALID = 0 and BUS_M_REQ = 0 in the first cycle after reset deassertion only if credit is exhausted; otherwise REQ rises immediately.
- BUS_M_REQ = (state==RUN) & ~FETCH_FLUSH & (fifo_count + outstanding < DEPTH). REQ does not depend on BUS_M_ACK. No combinational loop.
- On BUS_M_ACK: fetch_pc += 4 (wraps modulo 2^32), outstanding += 1.
- Response: rsp = BUS_M_DONE[0] & ~BUS_M_DONE[1]. On rsp, outstanding -= 1.
  - If discard > 0: drop the response and decrement discard.
  - Otherwise: push {BUS_M_DONE[3], resp_pc, BUS_M_RDATA} and advance resp_pc += 4.
- Push is never refused; the credit rule guarantees space. A push into a full FIFO is an assertion failure.
- Push of an entry with BUSERR=1: state -> ERR_HOLD, and no further REQ is issued. Responses already in flight are still pushed normally.
- Simultaneous ACK and rsp in the same cycle: outstanding is unchanged. Simultaneous push and pop: fifo_count is unchanged. Max outstanding is 2 in steady state.
- FETCH_FLUSH (highest priority):
  - Same cycle: REQ is forced 0, any pop is ignored, and any response this cycle is dropped.
  - Next cycle: fifo is empty, fetch_pc = resp_pc = {FETCH_TARGET[31:2], 2'b00}, state = RUN, and discard = outstanding after this cycle's rsp (discard - 1 if a response consumed a discard slot this cycle).
- FETCH_VALID = fifo_count != 0. FETCH_DATA, FETCH_ADDR and FETCH_ERR are combinational from the head; they are 0 when the FIFO is empty.
- Reset mid-transfer: all state cleared. The adaptor is reset by the same RES_SYS, so no stale DONE can arrive.

Test Plan:
- Reset, zero-wait slave returning addr^32'hFFFFFFFF, FETCH_READY=1 -> ACKs at 0x90000000, 04, 08…; FETCH_DATA=0x6FFFFFFF first at 0x90000000; one word per cycle in steady state.
- FETCH_READY=0, DEPTH=4 -> exactly 4 ACKs, REQ then held low; FIFO holds 0x90000000..0C in order. Release READY -> fetching resumes at 0x90000010.
- Flush to 0x00001236 while 2 reads are outstanding -> both responses dropped; next ACK address 0x00001234; first FETCH_ADDR = 0x00001234.
- Flush in the same cycle as BUS_M_DONE and a pop -> response dropped, pop ignored, discard = 1 if one read is still outstanding.
- Slave returns HRESP=1 on 0x90000008 -> entry with FETCH_ERR=1; no REQ after in-flight reads complete. Flush to 0x100 -> REQ resumes at 0x100.
- Slave inserting 3 wait states on every access -> ordering is preserved, outstanding never exceeds 2, no FIFO overflow assertion fires.
